line_fill_mem: RTL and testbench
================================

# line_fill_mem

- Main-memory responder serving the instruction- and data-cache miss paths.
- Accepts 16-word line-fill requests and dirty-line writebacks, sequences word-by-word access to a 4096-line × 16-word × 16-bit backing array, and returns each filled line as a 256-bit bus with a one-cycle acknowledge.
- Sits between the cache block (`Block_Transfer` / `Data_Transfer` consumers) and the backing store.

## Interface
- `LAT`, 4: access wait cycles before the first word of any transfer (≥1).
- `LINES`, 4096: lines in the backing array; the line index is always 12 bits (address[15:4]).
- `Clk` in 1: sole clock; all logic on the rising edge.
- `Rst_n` in 1: synchronous, active-low reset.
- `I_Req` in 1: instruction line-fill request; level, held until `I_Ack`.
- `I_Addr` in 12: instruction fill line index (PC[15:4]).
- `D_Req` in 1: data request; level, held until `D_Ack`.
- `D_Addr` in 12: data fill line index.
- `D_Wb` in 1: victim line is dirty; write back before the fill.
- `D_Wb_Addr` in 12: victim line index.
- `D_Wb_Data` in 256: victim line; word k at [16k+15:16k].
- `Block_Transfer` out 256: instruction fill line; same word packing.
- `Data_Transfer` out 256: data fill line.
- `I_Ack` out 1: one-cycle pulse; `Block_Transfer` is valid.
- `D_Ack` out 1: one-cycle pulse; `Data_Transfer` is valid.
- `Busy` out 1: high in any state other than IDLE.
- `Par_Err` out 1: sticky parity error; see Configuration.

## Operation
- States: IDLE, WB_WAIT, WB_XFER, RD_WAIT, RD_XFER, ACK.
- IDLE:
  - `D_Req` has priority over `I_Req`.
  - On accept, latch the addresses, the requester, `D_Wb` and `D_Wb_Data`.
  - Go to WB_WAIT if `D_Wb` is set, else to RD_WAIT.
- WB_WAIT / RD_WAIT: hold for exactly `LAT` cycles (down-counter).
- WB_XFER: 16 cycles; cycle k writes word k of the latched victim line to mem[`D_Wb_Addr`][k]. Then go to RD_WAIT.
- RD_XFER: 16 cycles; cycle k reads mem[fill addr][k] into line-buffer word k. Then go to ACK.
- ACK:
  - One cycle: pulse the requester's Ack.
  - Drive the buffer onto the requester's output bus; return to IDLE.
- Output buses hold their value until the next fill for the same requester completes. The unused bus is untouched.
- Requesters deassert Req on the edge that samples Ack high. IDLE then sees Req low, so no double service.
- Request inputs are ignored outside IDLE.
- Writeback and fill to the same line index: the writeback completes first, so the fill returns the written-back data.
- `D_Wb` = 1 with `I_Req` pending: the data request is still served first. `I_Req` is accepted on the next IDLE cycle.
- Backing array is not cleared by reset. Unwritten locations read X.

## Timing
- Accept edge = cycle 0.
- Fill only: Ack is high in cycle `LAT`+17.
- Writeback + fill: Ack is high in cycle 2·`LAT`+33.
- `Busy` rises in cycle 1 and falls in the cycle after Ack.
- Back-to-back service: the next accept occurs at the earliest 2 cycles after Ack.
- Reset values:
  - `I_Ack`, `D_Ack`, `Busy`, `Par_Err` = 0.
  - `Block_Transfer`, `Data_Transfer` and the line buffer = 0.
  - State = IDLE; counters = 0.
- Reset mid-operation:
  - Abort to IDLE next edge; no Ack is issued.
  - Writeback words already written remain in memory; remaining words are not written.

## Configuration
- `LINE_FILL_PARITY_EN` defined:
  - Each array word stores an even-parity bit, computed on writeback.
  - On any RD_XFER word read with a mismatched parity bit, `Par_Err` is set and stays set until reset. Data is still returned.
  - Reads of never-written words do not flag.
- Not defined:
  - No parity storage.
  - `Par_Err` is tied to 0.

## Test plan
- Reset, LAT=4 → all outputs 0, `Busy`=0.
- D_Req, D_Wb=1, D_Wb_Addr=12'h005, words k = 16'h1000+k, D_Addr=12'h005 → `D_Ack` in cycle 41; `Data_Transfer` word k = 16'h1000+k.
- I_Req, I_Addr=12'h005, after the above → `I_Ack` in cycle 21; `Block_Transfer` equals the same line; `Data_Transfer` unchanged.
- I_Req and D_Req asserted in the same cycle (D_Wb=0) → `D_Ack` first; `I_Ack` exactly `LAT`+19 cycles later.
- Rst_n low in cycle 10 of a writeback to line 12'h0A0 (LAT=4) → IDLE next edge, no Ack; words 0–4 updated, words 5–15 unchanged.
- `LINE_FILL_PARITY_EN`: force a parity bit flip on mem[12'h005][3], then I_Req to 12'h005 → `Par_Err`=1, sticky until `Rst_n`.

Source files
------------

// File: rtl/line_fill_mem.sv
// Main-memory responder for the I/D cache miss paths: 16-word line fills and dirty writebacks
// over a 4096 x 16 x 16-bit array. Optional macro LINE_FILL_PARITY_EN adds per-word even parity.
module line_fill_mem #(
    parameter int LAT   = 4,
    parameter int LINES = 4096
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         I_Req,
    input  logic [11:0]  I_Addr,
    input  logic         D_Req,
    input  logic [11:0]  D_Addr,
    input  logic         D_Wb,
    input  logic [11:0]  D_Wb_Addr,
    input  logic [255:0] D_Wb_Data,
    output logic [255:0] Block_Transfer,
    output logic [255:0] Data_Transfer,
    output logic         I_Ack,
    output logic         D_Ack,
    output logic         Busy,
    output logic         Par_Err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WB_WAIT = 3'd1;
    localparam logic [2:0] WB_XFER = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_XFER = 3'd4;
    localparam logic [2:0] ACK     = 3'd5;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
`ifdef LINE_FILL_PARITY_EN
    localparam int MW = 17;
`else
    localparam int MW = 16;
`endif

    logic [MW-1:0]  mem [LINES*16];
    logic [2:0]     state;
    logic [CW-1:0]  wait_cnt;
    logic [3:0]     word;
    logic           post_ack;
    logic           is_d;
    logic [11:0]    fill_addr;
    logic [11:0]    wb_addr;
    logic [255:0]   wb_line;
    logic [255:0]   line_buf;
    logic [15:0]    rd_idx;
    logic [15:0]    wr_idx;
    logic [MW-1:0]  rd_ent;
    logic [15:0]    rd_word;
    logic [15:0]    wr_word;

    assign rd_idx  = {fill_addr, word};
    assign wr_idx  = {wb_addr, word};
    assign rd_ent  = mem[rd_idx];
    assign rd_word = rd_ent[15:0];
    assign wr_word = wb_line[{word, 4'b0} +: 16];

    assign Busy  = (state != IDLE);
    assign I_Ack = (state == ACK) && !is_d;
    assign D_Ack = (state == ACK) &&  is_d;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            word           <= '0;
            post_ack       <= 1'b0;
            is_d           <= 1'b0;
            fill_addr      <= '0;
            wb_addr        <= '0;
            wb_line        <= '0;
            line_buf       <= '0;
            Block_Transfer <= '0;
            Data_Transfer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The first IDLE cycle after ACK still sees the served requester's
                    // Req level, so acceptance waits one cycle.
                    post_ack <= 1'b0;
                    if (!post_ack && (D_Req || I_Req)) begin
                        is_d      <= D_Req;
                        fill_addr <= D_Req ? D_Addr : I_Addr;
                        wb_addr   <= D_Wb_Addr;
                        wb_line   <= D_Wb_Data;
                        wait_cnt  <= CW'(LAT - 1);
                        state     <= (D_Req && D_Wb) ? WB_WAIT : RD_WAIT;
                    end
                end
                WB_WAIT, RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        word  <= '0;
                        state <= (state == WB_WAIT) ? WB_XFER : RD_XFER;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WB_XFER: begin
                    word <= word + 4'd1;
                    if (word == 4'd15) begin
                        wait_cnt <= CW'(LAT - 1);
                        state    <= RD_WAIT;
                    end
                end
                RD_XFER: begin
                    line_buf[{word, 4'b0} +: 16] <= rd_word;
                    word <= word + 4'd1;
                    if (word == 4'd15) begin
                        // Merge the final word directly so the bus is valid during ACK.
                        if (is_d) Data_Transfer  <= {rd_word, line_buf[239:0]};
                        else      Block_Transfer <= {rd_word, line_buf[239:0]};
                        state <= ACK;
                    end
                end
                ACK: begin
                    post_ack <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents survive reset; a reset mid-writeback simply stops further writes.
    always_ff @(posedge Clk) begin
        if (Rst_n && state == WB_XFER) begin
`ifdef LINE_FILL_PARITY_EN
            mem[wr_idx] <= {^wr_word, wr_word};
`else
            mem[wr_idx] <= wr_word;
`endif
        end
    end

`ifdef LINE_FILL_PARITY_EN
    // Never-written words hold X parity, which does not take the mismatch branch.
    always_ff @(posedge Clk) begin
        if (!Rst_n)
            Par_Err <= 1'b0;
        else if (state == RD_XFER && rd_ent[16] != ^rd_ent[15:0])
            Par_Err <= 1'b1;
    end
`else
    assign Par_Err = 1'b0;
`endif

endmodule

// File: tb/tb_line_fill_mem.sv
// Randomized self-checking bench for line_fill_mem against a transaction-level timing/memory model.
module tb_line_fill_mem;
    localparam int LAT = 4;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         I_Req = 1'b0, D_Req = 1'b0, D_Wb = 1'b0;
    logic [11:0]  I_Addr = '0, D_Addr = '0, D_Wb_Addr = '0;
    logic [255:0] D_Wb_Data = '0;
    logic [255:0] Block_Transfer, Data_Transfer;
    logic         I_Ack, D_Ack, Busy, Par_Err;

    line_fill_mem #(.LAT(LAT), .LINES(4096)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .I_Req(I_Req), .I_Addr(I_Addr),
        .D_Req(D_Req), .D_Addr(D_Addr),
        .D_Wb(D_Wb), .D_Wb_Addr(D_Wb_Addr), .D_Wb_Data(D_Wb_Data),
        .Block_Transfer(Block_Transfer), .Data_Transfer(Data_Transfer),
        .I_Ack(I_Ack), .D_Ack(D_Ack), .Busy(Busy), .Par_Err(Par_Err)
    );

    always #5 Clk = ~Clk;

    int nvec = 0, nmis = 0, cyc = 0;
    bit chk_on = 1'b0;

    // Model: memory image, one in-flight transaction described by accept edge and length.
    logic [15:0]  mm [65536];
    bit           flip [65536];
    bit           pend = 1'b0, p_d, p_wb;
    int           p_e, p_a, next_ok = 0, mk, rs;
    logic [11:0]  p_fill, p_wba;
    logic [255:0] p_line, e_blk = '0, e_dat = '0, ln;
    bit           e_par = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        cyc++;
        if (!Rst_n) begin
            pend = 1'b0; next_ok = cyc + 1;
            e_blk = '0; e_dat = '0; e_par = 1'b0;
        end else begin
            if (pend) begin
                mk = cyc - (p_e + LAT + 1);
                if (p_wb && mk >= 0 && mk < 16) begin
                    mm[{p_wba, 4'(mk)}] = p_line[16*mk +: 16];
                    flip[{p_wba, 4'(mk)}] = 1'b0;
                end
                rs = p_e + LAT + (p_wb ? LAT + 16 : 0);
                mk = cyc - rs - 1;
                if (mk >= 0 && mk < 16 && flip[{p_fill, 4'(mk)}]) e_par = 1'b1;
                if (cyc == p_e + p_a - 1) begin
                    for (int j = 0; j < 16; j++) ln[16*j +: 16] = mm[{p_fill, 4'(j)}];
                    if (p_d) e_dat = ln; else e_blk = ln;
                end
                if (cyc == p_e + p_a) pend = 1'b0;
            end
            if (!pend && cyc >= next_ok && (D_Req || I_Req)) begin
                pend   = 1'b1;
                p_d    = D_Req;
                p_wb   = D_Req && D_Wb;
                p_fill = D_Req ? D_Addr : I_Addr;
                p_wba  = D_Wb_Addr;
                p_line = D_Wb_Data;
                p_e    = cyc;
                p_a    = p_wb ? 2*LAT + 33 : LAT + 17;
                next_ok = cyc + p_a + 2;
            end
        end
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    bit e_busy, e_ack;
    initial forever begin
        @(negedge Clk);
        if (chk_on) begin
            e_busy = pend && cyc >= p_e && cyc <= p_e + p_a - 1;
            e_ack  = pend && cyc == p_e + p_a - 1;
            chk("busy", 256'(Busy), 256'(e_busy));
            chk("i_ack", 256'(I_Ack), 256'(e_ack && !p_d));
            chk("d_ack", 256'(D_Ack), 256'(e_ack && p_d));
            chk("block_transfer", Block_Transfer, e_blk);
            chk("data_transfer", Data_Transfer, e_dat);
            chk("par_err", 256'(Par_Err), 256'(e_par));
        end
    end

    // One requester transaction; returns ack latency in edges from the drive point.
    task automatic xact(input bit d, input logic [11:0] a, input bit wb,
                        input logic [11:0] wa, input logic [255:0] wd, output int lat);
        int t0;
        bit got;
        t0 = cyc;
        if (d) begin
            D_Req = 1'b1; D_Addr = a; D_Wb = wb; D_Wb_Addr = wa; D_Wb_Data = wd;
        end else begin
            I_Req = 1'b1; I_Addr = a;
        end
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge Clk);
            if (d ? D_Ack : I_Ack) got = 1'b1;
        end
        lat = got ? cyc - t0 : -1;
        if (!got) begin
            nvec++; nmis++;
            $display("FAIL ack_timeout: requester d=%0d got no ack, required one within 400 cycles", d);
        end
        @(posedge Clk); #1;
        if (d) begin D_Req = 1'b0; D_Wb = 1'b0; end
        else I_Req = 1'b0;
        @(posedge Clk); #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    logic [255:0] ln1000, ln_a, ln_b, ln_mix, rl;
    logic [11:0]  pool [8];
    int           lat_d, lat_i, t0, kind;
    logic [11:0]  fa, wa;

    initial begin
        for (int k = 0; k < 16; k++) begin
            ln1000[16*k +: 16] = 16'h1000 + 16'(k);
            ln_a[16*k +: 16]   = 16'h0A00 + 16'(k);
            ln_b[16*k +: 16]   = 16'hB000 + 16'(k);
            ln_mix[16*k +: 16] = (k < 5) ? 16'hB000 + 16'(k) : 16'h0A00 + 16'(k);
        end
        for (int i = 0; i < 8; i++) pool[i] = 12'h100 + 12'(i * 17);

        repeat (3) @(posedge Clk);
        #1;
        chk_on = 1'b1;
        @(negedge Clk);
        chk("reset_busy", 256'(Busy), 256'd0);
        chk("reset_acks", 256'({I_Ack, D_Ack}), 256'd0);
        chk("reset_par_err", 256'(Par_Err), 256'd0);
        chk("reset_block", Block_Transfer, 256'd0);
        chk("reset_data", Data_Transfer, 256'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Writeback then fill of the same line.
        xact(1'b1, 12'h005, 1'b1, 12'h005, ln1000, lat_d);
        chk("wb_fill_latency", 256'(lat_d), 256'd41);
        chk("wb_fill_data", Data_Transfer, ln1000);

        xact(1'b0, 12'h005, 1'b0, '0, '0, lat_i);
        chk("ifill_latency", 256'(lat_i), 256'd21);
        chk("ifill_block", Block_Transfer, ln1000);
        chk("ifill_data_untouched", Data_Transfer, ln1000);

        // Simultaneous requests: data side first, instruction LAT+19 later.
        fork
            xact(1'b1, 12'h005, 1'b0, '0, '0, lat_d);
            xact(1'b0, 12'h005, 1'b0, '0, '0, lat_i);
        join
        chk("prio_d_latency", 256'(lat_d), 256'd21);
        chk("prio_i_gap", 256'(lat_i - lat_d), 256'(LAT + 19));

        // Reset in cycle 10 of a writeback to 0x0A0.
        xact(1'b1, 12'h0A0, 1'b1, 12'h0A0, ln_a, lat_d);
        t0 = cyc;
        D_Req = 1'b1; D_Addr = 12'h005; D_Wb = 1'b1; D_Wb_Addr = 12'h0A0; D_Wb_Data = ln_b;
        while (cyc < t0 + 10) begin @(posedge Clk); #1; end
        Rst_n = 1'b0; D_Req = 1'b0; D_Wb = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        chk("abort_busy", 256'(Busy), 256'd0);
        chk("abort_data_cleared", Data_Transfer, 256'd0);
        @(posedge Clk); #1;
        xact(1'b0, 12'h0A0, 1'b0, '0, '0, lat_i);
        chk("abort_partial_line", Block_Transfer, ln_mix);

`ifdef LINE_FILL_PARITY_EN
        dut.mem[16'h0053][16] = ~dut.mem[16'h0053][16];
        flip[16'h0053] = 1'b1;
        xact(1'b0, 12'h005, 1'b0, '0, '0, lat_i);
        chk("par_err_set", 256'(Par_Err), 256'd1);
        chk("par_data_returned", Block_Transfer, ln1000);
        xact(1'b0, 12'h0A0, 1'b0, '0, '0, lat_i);
        chk("par_err_sticky", 256'(Par_Err), 256'd1);
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        chk("par_err_reset", 256'(Par_Err), 256'd0);
        @(posedge Clk); #1;
`endif

        // Seed a pool of lines, then a random mix of fills, writebacks and contention.
        for (int i = 0; i < 8; i++) xact(1'b1, pool[i], 1'b1, pool[i], rand_line(), lat_d);
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            fa = pool[$urandom_range(0, 7)];
            wa = pool[$urandom_range(0, 7)];
            rl = rand_line();
            case (kind)
                0: xact(1'b0, fa, 1'b0, '0, '0, lat_i);
                1: xact(1'b1, fa, 1'b0, wa, rl, lat_d);
                2: xact(1'b1, fa, 1'b1, wa, rl, lat_d);
                default: fork
                    xact(1'b1, fa, $urandom_range(0, 1) == 1, wa, rl, lat_d);
                    xact(1'b0, pool[$urandom_range(0, 7)], 1'b0, '0, '0, lat_i);
                join
            endcase
            repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
        end

        repeat (3) @(posedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
